// File: rtl/alu_cmd_ctrl.sv
// UART-side command initiator for the ALU.
// Collects a [FUN][A][B] frame, fires the ALU for one cycle, captures the
// result and flags, and streams [RES_LO][RES_HI][FLAGS] or a single error byte.
module alu_cmd_ctrl #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          ALU_FUN_WIDTH  = 4,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic [7:0]                 i_RX_DATA,
  input  logic                       i_RX_VALID,
  output logic [7:0]                 o_TX_DATA,
  output logic                       o_TX_VALID,
  input  logic                       i_TX_READY,
  output logic [ALU_FUN_WIDTH-1:0]   o_ALU_FUN,
  output logic [DATA_WIDTH-1:0]      o_ALU_A,
  output logic [DATA_WIDTH-1:0]      o_ALU_B,
  output logic                       o_ALU_EN,
  input  logic [2*DATA_WIDTH-1:0]    i_ALU_OUT,
  input  logic                       i_ALU_CF,
  input  logic                       i_ALU_OF,
  input  logic                       i_ALU_EF,
  input  logic                       i_ALU_ZF,
  input  logic                       i_ALU_VALID,
  output logic                       o_BUSY,
  output logic                       o_RX_DROP,
  output logic                       o_TIMEOUT
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_CAPT,
    S_TX_LO, S_TX_HI, S_TX_FLG, S_TX_ERR
  } state_t;

  state_t                      state_q, state_d;
  logic [ALU_FUN_WIDTH-1:0]    fun_q, fun_d;
  logic [DATA_WIDTH-1:0]       a_q, a_d;
  logic [DATA_WIDTH-1:0]       b_q, b_d;
  logic [2*DATA_WIDTH-1:0]     res_q, res_d;
  logic [7:0]                  flg_q, flg_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // The FUN byte's upper bits carry no meaning for the ALU.
  logic unused_fun_hi;
  assign unused_fun_hi = ^i_RX_DATA[7:ALU_FUN_WIDTH];

  assign o_ALU_FUN = fun_q;
  assign o_ALU_A   = a_q;
  assign o_ALU_B   = b_q;
  assign o_BUSY    = (state_q != S_IDLE);

  // State and datapath registers; async reset clears everything so a pending TX dies at once.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, frame collection, inter-byte timeout and response streaming.
  always_comb begin
    state_d    = state_q;
    fun_d      = fun_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    flg_d      = flg_q;
    cnt_d      = cnt_q;
    o_TX_DATA  = 8'h00;
    o_TX_VALID = 1'b0;
    o_ALU_EN   = 1'b0;
    o_RX_DROP  = 1'b0;
    o_TIMEOUT  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_RX_VALID) begin
          fun_d   = i_RX_DATA[ALU_FUN_WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_GET_A;
        end
      end
      S_GET_A, S_GET_B: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (i_RX_VALID) begin
          cnt_d = '0;
          if (state_q == S_GET_A) begin
            a_d     = i_RX_DATA[DATA_WIDTH-1:0];
            state_d = S_GET_B;
          end else begin
            b_d     = i_RX_DATA[DATA_WIDTH-1:0];
            state_d = S_EXEC;
          end
        end else if (cnt_q == CNT_LAST) begin
          o_TIMEOUT = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        o_ALU_EN  = 1'b1;
        o_RX_DROP = i_RX_VALID;
        state_d   = S_CAPT;
      end
      S_CAPT: begin
        o_RX_DROP = i_RX_VALID;
        if (i_ALU_VALID) begin
          res_d   = i_ALU_OUT;
          flg_d   = {4'b0000, i_ALU_CF, i_ALU_OF, i_ALU_EF, i_ALU_ZF};
          state_d = S_TX_LO;
        end else begin
          state_d = S_TX_ERR;
        end
      end
      S_TX_LO: begin
        o_TX_VALID = 1'b1;
        o_TX_DATA  = res_q[7:0];
        o_RX_DROP  = i_RX_VALID;
        if (i_TX_READY) state_d = S_TX_HI;
      end
      S_TX_HI: begin
        o_TX_VALID = 1'b1;
        o_TX_DATA  = res_q[15:8];
        o_RX_DROP  = i_RX_VALID;
        if (i_TX_READY) state_d = S_TX_FLG;
      end
      S_TX_FLG: begin
        o_TX_VALID = 1'b1;
        o_TX_DATA  = flg_q;
        o_RX_DROP  = i_RX_VALID;
        if (i_TX_READY) state_d = S_IDLE;
      end
      S_TX_ERR: begin
        o_TX_VALID = 1'b1;
        o_TX_DATA  = ERR_BYTE;
        o_RX_DROP  = i_RX_VALID;
        if (i_TX_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small registered ALU model.
module tb_alu_cmd_ctrl;

  localparam int TO = 40;

  logic        i_CLK, i_RST;
  logic [7:0]  i_RX_DATA;
  logic        i_RX_VALID;
  logic [7:0]  o_TX_DATA;
  logic        o_TX_VALID;
  logic        i_TX_READY;
  logic [3:0]  o_ALU_FUN;
  logic [7:0]  o_ALU_A, o_ALU_B;
  logic        o_ALU_EN;
  logic [15:0] i_ALU_OUT;
  logic        i_ALU_CF, i_ALU_OF, i_ALU_EF, i_ALU_ZF, i_ALU_VALID;
  logic        o_BUSY, o_RX_DROP, o_TIMEOUT;

  alu_cmd_ctrl #(.DATA_WIDTH(8), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(TO), .ERR_BYTE(8'hEE)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_RX_DATA(i_RX_DATA), .i_RX_VALID(i_RX_VALID),
    .o_TX_DATA(o_TX_DATA), .o_TX_VALID(o_TX_VALID), .i_TX_READY(i_TX_READY),
    .o_ALU_FUN(o_ALU_FUN), .o_ALU_A(o_ALU_A), .o_ALU_B(o_ALU_B), .o_ALU_EN(o_ALU_EN),
    .i_ALU_OUT(i_ALU_OUT), .i_ALU_CF(i_ALU_CF), .i_ALU_OF(i_ALU_OF),
    .i_ALU_EF(i_ALU_EF), .i_ALU_ZF(i_ALU_ZF), .i_ALU_VALID(i_ALU_VALID),
    .o_BUSY(o_BUSY), .o_RX_DROP(o_RX_DROP), .o_TIMEOUT(o_TIMEOUT)
  );

  initial begin
    i_CLK = 1'b0;
    forever #5 i_CLK = ~i_CLK;
  end

  // ALU model: ADD=0, MUL=2, anything else invalid; result one cycle after enable.
  always @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      i_ALU_OUT <= 16'h0; i_ALU_VALID <= 1'b0;
      i_ALU_CF <= 1'b0; i_ALU_OF <= 1'b0; i_ALU_EF <= 1'b0; i_ALU_ZF <= 1'b0;
    end else begin
      i_ALU_VALID <= 1'b0;
      if (o_ALU_EN) begin
        case (o_ALU_FUN)
          4'd0: begin
            i_ALU_OUT   <= {8'h00, o_ALU_A} + {8'h00, o_ALU_B};
            i_ALU_CF    <= ({1'b0, o_ALU_A} + {1'b0, o_ALU_B}) > 9'h0FF;
            i_ALU_OF    <= 1'b0;
            i_ALU_ZF    <= ({8'h00, o_ALU_A} + {8'h00, o_ALU_B}) == 16'h0;
            i_ALU_VALID <= 1'b1;
          end
          4'd2: begin
            i_ALU_OUT   <= o_ALU_A * o_ALU_B;
            i_ALU_CF    <= 1'b0;
            i_ALU_OF    <= (o_ALU_A * o_ALU_B) > 16'h00FF;
            i_ALU_ZF    <= (o_ALU_A * o_ALU_B) == 16'h0;
            i_ALU_VALID <= 1'b1;
          end
          default: i_ALU_VALID <= 1'b0;
        endcase
      end
    end
  end

  // Passive monitor, sampled on the falling edge.
  logic [7:0] txq[$];
  int en_cnt = 0, drop_cnt = 0, to_cnt = 0, stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge i_CLK) begin
    if (o_TX_VALID && i_TX_READY) txq.push_back(o_TX_DATA);
    if (o_ALU_EN)  en_cnt++;
    if (o_RX_DROP) drop_cnt++;
    if (o_TIMEOUT) to_cnt++;
    if (prev_stall && !i_RST && (!o_TX_VALID || o_TX_DATA != prev_data)) stab_err++;
    prev_stall = o_TX_VALID && !i_TX_READY && !i_RST;
    prev_data  = o_TX_DATA;
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0; // 0 always ready, 1 one-in-four, 2 never, 3 manual

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_CLK);
    #1;
    cyc++;
    case (rdy_mode)
      0: i_TX_READY = 1'b1;
      1: i_TX_READY = (cyc % 4 == 0);
      2: i_TX_READY = 1'b0;
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_RX_DATA  = b;
    i_RX_VALID = 1'b1;
    tick();
    i_RX_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && o_BUSY; i++) tick();
    check(tag, 32'(o_BUSY), 32'd0);
  endtask

  task automatic expect_tx(input string tag, input int base, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_b [3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    check({tag, "_cnt"}, 32'(txq.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      if (base + i < txq.size())
        check($sformatf("%s_b%0d", tag, i), 32'(txq[base + i]), 32'(exp_b[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int base, en0, drop0, to0;

  initial begin
    i_RST = 1'b1; i_RX_DATA = 8'h00; i_RX_VALID = 1'b0; i_TX_READY = 1'b0;
    repeat (2) @(posedge i_CLK);
    #1;
    check("rst_busy", 32'(o_BUSY), 0);
    check("rst_txv", 32'(o_TX_VALID), 0);
    check("rst_en", 32'(o_ALU_EN), 0);
    check("rst_a", 32'(o_ALU_A), 0);
    check("rst_fun", 32'(o_ALU_FUN), 0);
    #2 i_RST = 1'b0;
    tick();

    // ADD F0+20 = 0x110, CF set; upper FUN nibble ignored; latency 3 cycles.
    base = txq.size(); en0 = en_cnt;
    send_byte(8'hA0); send_byte(8'hF0); send_byte(8'h20);
    check("add_fun", 32'(o_ALU_FUN), 0);
    check("add_a", 32'(o_ALU_A), 32'hF0);
    check("add_b", 32'(o_ALU_B), 32'h20);
    check("add_en", 32'(o_ALU_EN), 1);
    tick();
    check("add_en_once", 32'(o_ALU_EN), 0);
    check("add_capt_txv", 32'(o_TX_VALID), 0);
    tick();
    check("add_lat_txv", 32'(o_TX_VALID), 1);
    check("add_lat_data", 32'(o_TX_DATA), 32'h10);
    wait_idle("add_idle", 20);
    check("add_txv_off", 32'(o_TX_VALID), 0);
    check("add_en_cnt", 32'(en_cnt - en0), 1);
    expect_tx("add", base, 3, 8'h10, 8'h01, 8'h08);

    // MUL FF*FF = 0xFE01, OF set, with a 1-in-4 ready pattern.
    rdy_mode = 1; base = txq.size();
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
    wait_idle("mul_idle", 100);
    expect_tx("mul", base, 3, 8'h01, 8'hFE, 8'h04);
    check("mul_stable", 32'(stab_err), 0);
    rdy_mode = 0;

    // Invalid opcode: single error byte.
    base = txq.size();
    send_byte(8'h0F); send_byte(8'h12); send_byte(8'h34);
    wait_idle("err_idle", 20);
    expect_tx("err", base, 1, 8'hEE, 8'h00, 8'h00);

    // Timeout after FUN and A; operands stay stale.
    to0 = to_cnt;
    send_byte(8'h00); send_byte(8'h11);
    repeat (TO - 2) tick();
    check("to_early", 32'(o_TIMEOUT), 0);
    check("to_busy", 32'(o_BUSY), 1);
    tick();
    check("to_pulse", 32'(o_TIMEOUT), 1);
    tick();
    check("to_idle", 32'(o_BUSY), 0);
    check("to_pulse_off", 32'(o_TIMEOUT), 0);
    check("to_stale_a", 32'(o_ALU_A), 32'h11);
    check("to_cnt", 32'(to_cnt - to0), 1);

    // Byte on the expiry cycle is accepted; frame 05+03 completes.
    to0 = to_cnt; base = txq.size();
    send_byte(8'h00);
    repeat (TO - 1) tick();
    i_RX_DATA = 8'h05; i_RX_VALID = 1'b1; #1;
    check("race_no_to", 32'(o_TIMEOUT), 0);
    tick(); i_RX_VALID = 1'b0;
    send_byte(8'h03);
    wait_idle("race_idle", 20);
    check("race_to_cnt", 32'(to_cnt - to0), 0);
    expect_tx("race", base, 3, 8'h08, 8'h00, 8'h00);

    // Extra RX byte during TX_HI is dropped; response intact.
    rdy_mode = 3; i_TX_READY = 1'b0; base = txq.size(); drop0 = drop_cnt;
    send_byte(8'h00); send_byte(8'hC0); send_byte(8'h80);
    tick(); tick();
    i_TX_READY = 1'b1; tick(); i_TX_READY = 1'b0;
    i_RX_DATA = 8'h77; i_RX_VALID = 1'b1; #1;
    check("drop_pulse", 32'(o_RX_DROP), 1);
    tick(); i_RX_VALID = 1'b0;
    check("drop_hi_txv", 32'(o_TX_VALID), 1);
    check("drop_hi_data", 32'(o_TX_DATA), 32'h01);
    i_TX_READY = 1'b1; rdy_mode = 0;
    wait_idle("drop_idle", 20);
    check("drop_cnt", 32'(drop_cnt - drop0), 1);
    expect_tx("drop", base, 3, 8'h40, 8'h01, 8'h08);

    // Async reset while stalled in TX_HI.
    rdy_mode = 3; i_TX_READY = 1'b0;
    send_byte(8'h00); send_byte(8'hC0); send_byte(8'h80);
    tick(); tick();
    i_TX_READY = 1'b1; tick(); i_TX_READY = 1'b0;
    tick(); tick();
    check("rst2_pre_txv", 32'(o_TX_VALID), 1);
    #2 i_RST = 1'b1; #1;
    check("rst2_txv", 32'(o_TX_VALID), 0);
    check("rst2_data", 32'(o_TX_DATA), 0);
    check("rst2_busy", 32'(o_BUSY), 0);
    check("rst2_a", 32'(o_ALU_A), 0);
    check("rst2_b", 32'(o_ALU_B), 0);
    tick();
    i_RST = 1'b0; rdy_mode = 0;
    tick();
    check("rst2_after", 32'(o_BUSY), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
